// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states, response bytes and
// the word-index to byte-address helper.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StChk,
    StAck,
    StNak,
    StDone
  } state_e;

  localparam logic [7:0] AckByte    = 8'h06;
  localparam logic [7:0] NakByte    = 8'h15;
  localparam logic [7:0] DefHdrByte = 8'hA5;

  // Word index to word-aligned byte address in the IF fetch-address format.
  function automatic logic [30:0] word_addr(input logic [15:0] idx);
    return {13'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_boot_loader_byte_timeout.sv
// Inter-byte watchdog: counts enabled idle cycles and pulses expire_o once Limit is reached.
module imem_boot_loader_byte_timeout #(
  parameter int unsigned Limit = 1_000_000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Limit of zero disables the watchdog entirely.
  assign expire_o = (Limit != 0) && en_i && !clr_i && (cnt_q == 32'(Limit - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Receives a framed program image over the UART, writes it into instruction RAM and releases
// the CPU from reset once the image checksum matches.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned MaxWords = 256,
  parameter logic [7:0]  HdrByte  = DefHdrByte,
  parameter int unsigned Timeout  = 1_000_000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        tx_busy_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_start_o,
  output logic        imem_we_o,
  output logic [30:0] imem_waddr_o,
  output logic [31:0] imem_wdata_o,
  output logic        cpu_hold_o,
  output logic        boot_done_o,
  output logic        boot_err_o
);

  localparam int unsigned IdxW = $clog2(MaxWords) + 1;

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       word_q, word_d;
  logic [7:0]        sum_q, sum_d;
  logic              we_q, we_d;
  logic [30:0]       waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              active;
  logic              expire;

  assign active = (state_q == StLenHi) || (state_q == StLenLo) ||
                  (state_q == StData)  || (state_q == StChk);

  imem_boot_loader_byte_timeout #(
    .Limit (Timeout)
  ) u_byte_timeout (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clr_i    (rx_valid_i || !active),
    .en_i     (active),
    .expire_o (expire)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    sum_d      = sum_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    tx_start_o = 1'b0;
    tx_data_o  = 8'h00;

    unique case (state_q)
      StIdle: begin
        len_d  = '0;
        idx_d  = '0;
        bcnt_d = '0;
        sum_d  = '0;
        if (rx_valid_i && (rx_data_i == HdrByte)) begin
          state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (rx_valid_i) begin
          len_d   = {rx_data_i, 8'h00};
          state_d = StLenLo;
        end
      end
      StLenLo: begin
        if (rx_valid_i) begin
          len_d = {len_q[15:8], rx_data_i};
          if ((len_d == 16'd0) || ({16'd0, len_d} > MaxWords)) begin
            state_d = StNak;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (rx_valid_i) begin
          sum_d  = sum_q + rx_data_i;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = word_addr(16'(idx_q));
            wdata_d = {word_q, rx_data_i};
            idx_d   = idx_q + IdxW'(1);
            if (16'(idx_q) + 16'd1 == len_q) begin
              state_d = StChk;
            end
          end else begin
            word_d = {word_q[15:0], rx_data_i};
          end
        end
      end
      StChk: begin
        if (rx_valid_i) begin
          state_d = (rx_data_i == sum_q) ? StAck : StNak;
        end
      end
      StAck: begin
        tx_data_o = AckByte;
        if (!tx_busy_i) begin
          tx_start_o = 1'b1;
          state_d    = StDone;
        end
      end
      StNak: begin
        tx_data_o = NakByte;
        if (!tx_busy_i) begin
          tx_start_o = 1'b1;
          state_d    = StIdle;
        end
      end
      StDone: begin
      end
      default: state_d = StIdle;
    endcase

    // Watchdog only fires in active states on cycles without a byte.
    if (expire) begin
      state_d = StNak;
    end

    err_d = (state_d == StNak) && (state_q != StNak);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign imem_we_o    = we_q;
  assign imem_waddr_o = waddr_q;
  assign imem_wdata_o = wdata_q;
  assign boot_err_o   = err_q;
  assign cpu_hold_o   = (state_q != StDone);
  assign boot_done_o  = (state_q == StDone);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: framed loads, checksum/length errors, timeout, tx back-pressure
// and reset abort, with expected values written out by hand.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        imem_we;
  logic [30:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        boot_done;
  logic        boot_err;

  imem_boot_loader #(
    .MaxWords (256),
    .HdrByte  (8'hA5),
    .Timeout  (100)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .tx_busy_i    (tx_busy),
    .tx_data_o    (tx_data),
    .tx_start_o   (tx_start),
    .imem_we_o    (imem_we),
    .imem_waddr_o (imem_waddr),
    .imem_wdata_o (imem_wdata),
    .cpu_hold_o   (cpu_hold),
    .boot_done_o  (boot_done),
    .boot_err_o   (boot_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic [30:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          we_cyc_q[$];
  int          word_strobe_q[$];
  logic [7:0]  tx_q[$];
  int          tx_cyc = 0;
  int          err_n = 0;
  int          err_cyc = 0;
  int          hold_fall_cyc = 0;
  int          busy_viol = 0;
  int          strobe_cyc = 0;
  logic        hold_prev = 1'b1;

  always @(negedge clk) begin
    if (imem_we) begin
      wa_q.push_back(imem_waddr);
      wd_q.push_back(imem_wdata);
      we_cyc_q.push_back(cyc);
    end
    if (tx_start) begin
      tx_q.push_back(tx_data);
      tx_cyc = cyc;
      if (tx_busy) busy_viol++;
    end
    if (boot_err) begin
      err_n++;
      err_cyc = cyc;
    end
    if (hold_prev && !cpu_hold) hold_fall_cyc = cyc;
    hold_prev = cpu_hold;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_wa(input int i);
    return (wa_q.size() > i) ? {1'b0, wa_q[i]} : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] get_wd(input int i);
    return (wd_q.size() > i) ? wd_q[i] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] get_tx(input int i);
    return (tx_q.size() > i) ? {24'd0, tx_q[i]} : 32'hxxxxxxxx;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data    = b;
    rx_valid   = 1'b1;
    strobe_cyc = cyc;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    word_strobe_q.push_back(strobe_cyc);
  endtask

  task automatic send_frame2(input logic [31:0] w0, input logic [31:0] w1, input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(w0);
    send_word(w1);
    send_byte(chk);
  endtask

  task automatic wait_tx(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && tx_q.size() < n; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check(tag, tx_q.size(), n);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    rx_valid = 1'b0;
    tx_busy  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wa_q.delete();
    wd_q.delete();
    we_cyc_q.delete();
    word_strobe_q.delete();
    tx_q.delete();
    err_n = 0;
  endtask

  // Data bytes 20+08+00+03+8E+04+00+00 sum to 0xBD modulo 256.
  localparam logic [31:0] W0   = 32'h20080003;
  localparam logic [31:0] W1   = 32'h8E040000;
  localparam logic [7:0]  GOOD = 8'hBD;

  initial begin
    int rel_cyc;
    int last_cyc;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_busy  = 1'b0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_hold", cpu_hold, 1);
    check("rst_done", boot_done, 0);
    check("rst_outs", {tx_start, imem_we, boot_err, tx_data}, 0);
    check("rst_waddr", imem_waddr, 0);

    // T1: good two-word frame
    send_frame2(W0, W1, GOOD);
    wait_tx("t1_txn", 1, 20);
    check("t1_nwr", wa_q.size(), 2);
    check("t1_a0", get_wa(0), 0);
    check("t1_d0", get_wd(0), W0);
    check("t1_a1", get_wa(1), 4);
    check("t1_d1", get_wd(1), W1);
    check("t1_we_lat0", we_cyc_q[0] - word_strobe_q[0], 1);
    check("t1_we_lat1", we_cyc_q[1] - word_strobe_q[1], 1);
    check("t1_tx", get_tx(0), 8'h06);
    check("t1_hold_lat", hold_fall_cyc - tx_cyc, 1);
    check("t1_done", boot_done, 1);
    check("t1_hold", cpu_hold, 0);
    check("t1_err", err_n, 0);
    // Bytes after DONE are ignored
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_word(W0); send_byte(8'hBD);
    repeat (5) @(negedge clk);
    check("t1_post_nwr", wa_q.size(), 2);
    check("t1_post_ntx", tx_q.size(), 1);
    check("t1_post_done", boot_done, 1);

    // T2: bad checksum, then resend
    do_reset();
    @(negedge clk);
    check("t2_rst_done", boot_done, 0);
    check("t2_rst_hold", cpu_hold, 1);
    send_frame2(W0, W1, 8'hBE);
    wait_tx("t2_txn", 1, 20);
    check("t2_nwr", wa_q.size(), 2);
    check("t2_err", err_n, 1);
    check("t2_tx", get_tx(0), 8'h15);
    check("t2_hold", cpu_hold, 1);
    check("t2_done", boot_done, 0);
    send_frame2(W0, W1, GOOD);
    wait_tx("t2_txn2", 2, 20);
    check("t2_tx2", get_tx(1), 8'h06);
    check("t2_a2", get_wa(2), 0);
    check("t2_d3", get_wd(3), W1);
    check("t2_done2", boot_done, 1);

    // T3: zero length and oversize length
    do_reset();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    wait_tx("t3_txn", 1, 20);
    check("t3_tx0", get_tx(0), 8'h15);
    check("t3_err0", err_n, 1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
    wait_tx("t3_txn2", 2, 20);
    check("t3_tx1", get_tx(1), 8'h15);
    check("t3_err1", err_n, 2);
    check("t3_nwr", wa_q.size(), 0);
    check("t3_hold", cpu_hold, 1);

    // T4: stall after 5 data bytes; delay counted from the edge that sampled the last byte
    do_reset();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_word(W0);
    send_byte(8'h8E);
    last_cyc = strobe_cyc;
    for (int i = 0; i < 300 && err_n == 0; i++) @(negedge clk);
    check("t4_err", err_n, 1);
    check("t4_delay", err_cyc - (last_cyc + 1), 100);
    wait_tx("t4_txn", 1, 20);
    check("t4_tx", get_tx(0), 8'h15);
    check("t4_nwr", wa_q.size(), 1);
    send_frame2(W0, W1, GOOD);
    wait_tx("t4_txn2", 2, 20);
    check("t4_a1", get_wa(1), 0);
    check("t4_a2", get_wa(2), 4);
    check("t4_done", boot_done, 1);

    // T5: tx_busy held at ACK, rx bytes while waiting are dropped
    do_reset();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_word(W0);
    send_word(W1);
    tx_busy = 1'b1;
    send_byte(GOOD);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    repeat (44) @(posedge clk);
    check("t5_ntx_busy", tx_q.size(), 0);
    check("t5_hold_busy", cpu_hold, 1);
    @(posedge clk);
    #1;
    tx_busy = 1'b0;
    rel_cyc = cyc;
    wait_tx("t5_txn", 1, 10);
    check("t5_tx_cyc", tx_cyc - rel_cyc, 0);
    check("t5_tx", get_tx(0), 8'h06);
    check("t5_nwr", wa_q.size(), 2);
    check("t5_done", boot_done, 1);

    // T6: reset mid-data, then a full frame
    do_reset();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h08); send_byte(8'h00);
    do_reset();
    send_frame2(W0, W1, GOOD);
    wait_tx("t6_txn", 1, 20);
    check("t6_a0", get_wa(0), 0);
    check("t6_d0", get_wd(0), W0);
    check("t6_a1", get_wa(1), 4);
    check("t6_done", boot_done, 1);
    check("t6_hold", cpu_hold, 0);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    repeat (5) @(negedge clk);
    check("t6_post_nwr", wa_q.size(), 2);
    check("busy_viol", busy_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
